// File: rtl/fft_out_reorder.sv
// fft_out_reorder: reorders 32-point bit-reversed FFT result frames into natural order through a ping-pong buffer.
// Optional FFT_REORDER_FFTSHIFT_EN: emit bins rotated by N/2 so the DC bin lands at output position N/2.
`default_nettype none

module fft_out_reorder #(
    parameter int NB    = 16,
    parameter int LOG2N = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [NB-1:0]    dr_i,
    input  logic [NB-1:0]    di_i,
    output logic [NB-1:0]    dr_o,
    output logic [NB-1:0]    di_o,
    output logic             valid_o,
    output logic             rdy_o,
    output logic [LOG2N-1:0] idx_o,
    output logic             err_o
);

    localparam int              N    = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_FILL = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_OUT  = 1'b1;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    logic [0:0]       wr_state, wr_state_nxt;
    logic [0:0]       rd_state, rd_state_nxt;
    logic [LOG2N-1:0] wr_cnt;
    logic             wr_bank;
    logic             rd_bank;
    logic [LOG2N-1:0] rd_pos;
    logic [1:0]       full;

    logic             wr_en, wr_first, abort, wr_done;
    logic             rd_en, rd_done;
    logic [LOG2N-1:0] wr_addr;
    logic [LOG2N-1:0] rd_addr;

    logic [2*NB-1:0]  mem [0:2*N-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
        end
    end

    always_comb begin
        wr_state_nxt = wr_state;
        rd_state_nxt = rd_state;
        case (wr_state)
            W_IDLE:  if (start_i) wr_state_nxt = W_FILL;
            default: if (wr_cnt == LAST) wr_state_nxt = W_IDLE;
        endcase
        case (rd_state)
            R_IDLE:  if (full[rd_bank]) rd_state_nxt = R_OUT;
            default: if (rd_pos == LAST && !full[rd_bank ^ 1'b1]) rd_state_nxt = R_IDLE;
        endcase
    end

    // A start on the last sample of a frame is not honoured; the frame completes.
    always_comb begin
        abort    = (wr_state == W_FILL) && start_i && (wr_cnt != LAST);
        wr_first = ((wr_state == W_IDLE) && start_i) || abort;
        wr_en    = ((wr_state == W_IDLE) && start_i) || (wr_state == W_FILL);
        wr_done  = (wr_state == W_FILL) && (wr_cnt == LAST);
        rd_en    = (rd_state == R_OUT);
        rd_done  = (rd_state == R_OUT) && (rd_pos == LAST);
    end

    assign wr_addr = bitrev(wr_first ? '0 : wr_cnt);
`ifdef FFT_REORDER_FFTSHIFT_EN
    assign rd_addr = rd_pos ^ LOG2N'(N / 2);
`else
    assign rd_addr = rd_pos;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            rd_pos  <= '0;
            full    <= 2'b00;
            dr_o    <= '0;
            di_o    <= '0;
            valid_o <= 1'b0;
            rdy_o   <= 1'b0;
            idx_o   <= '0;
            err_o   <= 1'b0;
        end else begin
            if (wr_first)                   wr_cnt <= ONE;
            else if (wr_state == W_FILL)    wr_cnt <= wr_cnt + ONE;
            if (wr_done) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            // Wraps to 0 after the last address, ready for the next frame.
            if (rd_en) rd_pos <= rd_pos + ONE;
            if (rd_done) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
            valid_o <= rd_en;
            rdy_o   <= rd_en && (rd_pos == '0);
            idx_o   <= rd_en ? rd_addr : '0;
            dr_o    <= rd_en ? mem[{rd_bank, rd_addr}][2*NB-1:NB] : '0;
            di_o    <= rd_en ? mem[{rd_bank, rd_addr}][NB-1:0]    : '0;
            err_o   <= abort;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[{wr_bank, wr_addr}] <= {dr_i, di_i};
    end

endmodule

`default_nettype wire

// File: tb/tb_fft_out_reorder.sv
// Scoreboard testbench for fft_out_reorder: driver queues expected bins, negedge monitor compares.
`default_nettype none

module tb_fft_out_reorder;

    localparam int LAT = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dr_in, di_in, dr_out, di_out;
    logic        valid, rdy, err;
    logic [4:0]  idx;

    always #5 clk = ~clk;

    fft_out_reorder #(.NB(16), .LOG2N(5)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .dr_i(dr_in), .di_i(di_in),
        .dr_o(dr_out), .di_o(di_out), .valid_o(valid), .rdy_o(rdy), .idx_o(idx), .err_o(err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] dr;
        logic [15:0] di;
        logic [4:0]  idx;
        logic        rdy;
    } exp_t;

    exp_t sb[$];
    int   err_q[$];
    int   nvec = 0;
    int   nfail = 0;

    function automatic logic [4:0] brev(input logic [4:0] a);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = a[4-i];
        return r;
    endfunction

    // Monitor
    exp_t e;
    logic exp_err;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                nvec++; nfail++;
                $display("FAIL missing_output: idx %0d due at cycle %0d not seen (now %0d)", sb[0].idx, sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            nvec++;
            if (valid === 1'b1) begin
                if (sb.size() == 0) begin
                    nfail++;
                    $display("FAIL unexpected_valid: cycle %0d dr %0d idx %0d, required no output", cyc, dr_out, idx);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || dr_out !== e.dr || di_out !== e.di || idx !== e.idx || rdy !== e.rdy) begin
                        nfail++;
                        $display("FAIL output: got cyc %0d dr %0d di %0d idx %0d rdy %0b, required cyc %0d dr %0d di %0d idx %0d rdy %0b",
                                 cyc, dr_out, di_out, idx, rdy, e.cyc, e.dr, e.di, e.idx, e.rdy);
                    end
                end
            end else if (dr_out !== 16'd0 || di_out !== 16'd0 || idx !== 5'd0 || rdy !== 1'b0 || valid !== 1'b0) begin
                nfail++;
                $display("FAIL idle_outputs: cycle %0d valid %b dr %0d di %0d idx %0d rdy %b, required all 0",
                         cyc, valid, dr_out, di_out, idx, rdy);
            end
            exp_err = (err_q.size() > 0 && err_q[0] == cyc);
            if (exp_err) void'(err_q.pop_front());
            if (err !== 1'b0 || exp_err) begin
                nvec++;
                if (err !== exp_err) begin
                    nfail++;
                    $display("FAIL err_pulse: cycle %0d err %b, required %b", cyc, err, exp_err);
                end
            end
        end
    end

    task automatic send_frame(input int br, input int bi, input int nsamp, input bit push,
                              input bit restart, output int t0);
        int a;
        for (int k = 0; k < nsamp; k++) begin
            @(negedge clk);
            start = (k == 0);
            dr_in = 16'(br + k);
            di_in = 16'(bi + k);
            if (k == 0) begin
                t0 = cyc + 1;
                if (restart) err_q.push_back(t0);
                if (push) begin
                    for (int m = 0; m < 32; m++) begin
`ifdef FFT_REORDER_FFTSHIFT_EN
                        a = (m + 16) % 32;
`else
                        a = m;
`endif
                        sb.push_back('{t0 + LAT + m, 16'(br + brev(5'(a))), 16'(bi + brev(5'(a))), 5'(a), (m == 0)});
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            dr_in = rnd ? 16'($urandom) : 16'd0;
            di_in = rnd ? 16'($urandom) : 16'd0;
        end
    endtask

    task automatic check_zero(input string tag);
        nvec++;
        if (valid !== 1'b0 || rdy !== 1'b0 || err !== 1'b0 || dr_out !== 16'd0 || di_out !== 16'd0 || idx !== 5'd0) begin
            nfail++;
            $display("FAIL %s: valid %b rdy %b err %b dr %0d di %0d idx %0d, required all 0",
                     tag, valid, rdy, err, dr_out, di_out, idx);
        end
    endtask

    // Hand-computed bins of frame dr=k, di=k+32 at fixed output positions
    task automatic check_at(input int t, input int m, input int xdr, input int xdi, input int xidx, input bit xrdy);
        while (cyc < t) @(negedge clk);
        #1;
        nvec++;
        if (valid !== 1'b1 || dr_out !== 16'(xdr) || di_out !== 16'(xdi) || idx !== 5'(xidx) || rdy !== xrdy) begin
            nfail++;
            $display("FAIL directed_m%0d: valid %b dr %0d di %0d idx %0d rdy %b, required 1 %0d %0d %0d %b",
                     m, valid, dr_out, di_out, idx, rdy, xdr, xdi, xidx, xrdy);
        end
    endtask

    int t0, tdummy;
    int hm[4], hdr[4], hidx[4];

    initial begin
`ifdef FFT_REORDER_FFTSHIFT_EN
        hm = '{0, 1, 16, 31}; hdr = '{1, 17, 0, 30}; hidx = '{16, 17, 0, 15};
`else
        hm = '{0, 1, 3, 31};  hdr = '{0, 16, 24, 31}; hidx = '{0, 1, 3, 31};
`endif
        rst = 1'b1; start = 1'b0; dr_in = '0; di_in = '0;
        @(negedge clk); @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;
        idle(3, 1'b0);

        // Single frame with directed spot checks
        send_frame(0, 32, 32, 1'b1, 1'b0, t0);
        for (int i = 0; i < 4; i++)
            check_at(t0 + LAT + hm[i], hm[i], hdr[i], hdr[i] + 32, hidx[i], hm[i] == 0);
        idle(10, 1'b0);

        // Back-to-back frames: 64 contiguous valid cycles
        send_frame(0, 32, 32, 1'b1, 1'b0, tdummy);
        send_frame(100, 132, 32, 1'b1, 1'b0, tdummy);
        idle(40, 1'b0);

        // Abort at sample 10, restart frame
        send_frame(200, 250, 10, 1'b0, 1'b0, tdummy);
        send_frame(300, 400, 32, 1'b1, 1'b1, tdummy);
        idle(40, 1'b0);

        // Reset during output position 5
        send_frame(500, 600, 32, 1'b1, 1'b0, t0);
        while (cyc < t0 + LAT + 5) @(negedge clk);
        #2 rst = 1'b1;
        sb.delete();
        err_q.delete();
        #1 check_zero("reset_mid_output");
        idle(3, 1'b0);
        rst = 1'b0;

        // Idle random inputs: no output may appear
        idle(100, 1'b1);

        nvec++;
        if (sb.size() != 0 || err_q.size() != 0) begin
            nfail++;
            $display("FAIL drain: %0d outputs and %0d err pulses outstanding, required 0 0", sb.size(), err_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire
